// File: rtl/bk_adder_pipe_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bk_pkg : shared constants and prefix-cell helpers for the Brent-Kung adder
// Revision: 1.0
// ---------------------------------------------------------------------------
package bk_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    function automatic int bk_levels(input int width);
        return (width <= 2) ? 1 : 2 * $clog2(width) - 1;
    endfunction

    // Combining distance of a tree level: doubles on the up-sweep, halves on the down-sweep.
    function automatic int bk_span(input int width, input int level);
        int up_levels;
        up_levels = $clog2(width);
        return (level <= up_levels) ? (1 << (level - 1)) : (1 << (2 * up_levels - 1 - level));
    endfunction

    function automatic logic [1:0] bk_black(input logic g1, input logic p1,
                                            input logic g0, input logic p0);
        return {g1 | (p1 & g0), p1 & p0};
    endfunction

    function automatic logic bk_grey(input logic g1, input logic p1, input logic g0);
        return g1 | (p1 & g0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bk_adder_pipe_prefix_level.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bk_prefix_level : one level of the Brent-Kung prefix tree (up or down sweep)
// Revision: 1.0
// ---------------------------------------------------------------------------
module bk_prefix_level
    import bk_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int LEVEL = 1
) (
    input  logic [WIDTH-1:0] g_i,
    input  logic [WIDTH-1:0] p_i,
    output logic [WIDTH-1:0] g_o,
    output logic [WIDTH-1:0] p_o
);
    localparam int UP_LEVELS = $clog2(WIDTH);
    localparam int SPAN      = bk_span(WIDTH, LEVEL);
    localparam bit UP        = (LEVEL <= UP_LEVELS);

    // Down-sweep nodes only need the final carry, so they use grey cells.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (UP && (((i + 1) % (2 * SPAN)) == 0)) begin : g_black
            assign {g_o[i], p_o[i]} = bk_black(g_i[i], p_i[i], g_i[i-SPAN], p_i[i-SPAN]);
        end else if (!UP && (i >= 3 * SPAN - 1) && (((i + 1) % (2 * SPAN)) == SPAN)) begin : g_grey
            assign g_o[i] = bk_grey(g_i[i], p_i[i], g_i[i-SPAN]);
            assign p_o[i] = p_i[i];
        end else begin : g_pass
            assign g_o[i] = g_i[i];
            assign p_o[i] = p_i[i];
        end
    end

endmodule
`default_nettype wire

// File: rtl/bk_adder_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bk_adder_pipe : pipelined Brent-Kung adder/subtractor with valid/ready flow
// Revision: 1.0
// ---------------------------------------------------------------------------
module bk_adder_pipe
    import bk_pkg::*;
#(
    parameter int WIDTH       = 64,
    parameter int PIPE_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int LEVELS = bk_levels(WIDTH);
    localparam int S      = PIPE_STAGES;

    // Stage index registered right after the given prefix level, 0 if none.
    function automatic int stage_at(input int lvl);
        int r;
        r = 0;
        for (int k = 1; k < S; k++) begin
            if (((k * LEVELS) / S) == lvl) r = k;
        end
        return r;
    endfunction

    logic [S:1] valid_q, valid_d, adv, vprev;

    always_comb begin
        adv     = '0;
        vprev   = '0;
        valid_d = valid_q;
        vprev[1] = in_valid;
        for (int k = 2; k <= S; k++) vprev[k] = valid_q[k-1];
        for (int k = 1; k <= S; k++) begin
            adv[k] = out_ready;
            for (int j = k; j <= S; j++) begin
                if (!valid_q[j]) adv[k] = 1'b1;
            end
            if (adv[k]) valid_d[k] = vprev[k];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) valid_q <= '0;
        else       valid_q <= valid_d;
    end

    // Carry-in is folded into bit 0 so the tree output is directly c[i+1].
    logic [WIDTH-1:0] bb, p0, g0, x0;
    logic             c0;

    always_comb begin
        bb    = (sub == OP_ADD) ? b : ~b;
        c0    = (sub == OP_SUB) ? 1'b1 : cin;
        p0    = a ^ bb;
        g0    = a & bb;
        g0[0] = g0[0] | (p0[0] & c0);
        x0    = p0;
        x0[0] = p0[0] ^ c0;
    end

    logic [WIDTH-1:0] lv_g [1:LEVELS+1];
    logic [WIDTH-1:0] lv_p [1:LEVELS+1];
    logic [WIDTH-1:0] lv_x [1:LEVELS+1];
    logic [WIDTH-1:0] lo_g [1:LEVELS];
    logic [WIDTH-1:0] lo_p [1:LEVELS];

    assign lv_g[1] = g0;
    assign lv_p[1] = p0;
    assign lv_x[1] = x0;

    for (genvar lv = 1; lv <= LEVELS; lv++) begin : g_level
        bk_prefix_level #(
            .WIDTH (WIDTH),
            .LEVEL (lv)
        ) u_level (
            .g_i (lv_g[lv]),
            .p_i (lv_p[lv]),
            .g_o (lo_g[lv]),
            .p_o (lo_p[lv])
        );
    end

    for (genvar lv = 2; lv <= LEVELS + 1; lv++) begin : g_link
        if (stage_at(lv - 1) != 0) begin : g_stage
            localparam int K = stage_at(lv - 1);
            logic [WIDTH-1:0] g_q, p_q, x_q;
            always_ff @(posedge clk) begin
                if (reset) begin
                    g_q <= '0;
                    p_q <= '0;
                    x_q <= '0;
                end else if (adv[K] && vprev[K]) begin
                    g_q <= lo_g[lv-1];
                    p_q <= lo_p[lv-1];
                    x_q <= lv_x[lv-1];
                end
            end
            assign lv_g[lv] = g_q;
            assign lv_p[lv] = p_q;
            assign lv_x[lv] = x_q;
        end else begin : g_comb
            assign lv_g[lv] = lo_g[lv-1];
            assign lv_p[lv] = lo_p[lv-1];
            assign lv_x[lv] = lv_x[lv-1];
        end
    end

    logic [WIDTH-1:0] gf, sum_d, sum_q;
    logic             cout_d, cout_q, ovf_d, ovf_q;

    always_comb begin
        gf     = lv_g[LEVELS+1];
        sum_d  = lv_x[LEVELS+1] ^ {gf[WIDTH-2:0], 1'b0};
        cout_d = gf[WIDTH-1];
        ovf_d  = gf[WIDTH-1] ^ gf[WIDTH-2];
    end

    // Loaded only on a real beat so the result holds while stalled or empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (adv[S] && vprev[S]) begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign out_valid = valid_q[S];
    assign in_ready  = adv[1];

endmodule
`default_nettype wire

// File: tb/tb_bk_adder_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bk_adder_pipe : directed and randomized checks over several WIDTH/S builds
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_bk_adder_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [63:0] a_s, b_s;
    logic        cin_s, sub_s, ordy;
    logic [5:0]  iv;
    wire  [5:0]  ir, ov, co, vf;
    wire  [31:0] s0, s1;
    wire  [13:0] s2;
    wire  [52:0] s3;
    wire  [1:0]  s4;
    wire  [63:0] s5;

    int          sel;
    int          checks = 0;
    int          errors = 0;
    int          npop   = 0;
    logic [63:0] sum_m;
    logic [65:0] sb [$];

    bk_adder_pipe #(.WIDTH(32), .PIPE_STAGES(2)) u0 (.clk(clk), .reset(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .a(a_s[31:0]), .b(b_s[31:0]), .cin(cin_s), .sub(sub_s), .out_valid(ov[0]), .out_ready(ordy), .sum(s0), .cout(co[0]), .ovf(vf[0]));
    bk_adder_pipe #(.WIDTH(32), .PIPE_STAGES(3)) u1 (.clk(clk), .reset(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .a(a_s[31:0]), .b(b_s[31:0]), .cin(cin_s), .sub(sub_s), .out_valid(ov[1]), .out_ready(ordy), .sum(s1), .cout(co[1]), .ovf(vf[1]));
    bk_adder_pipe #(.WIDTH(14), .PIPE_STAGES(7)) u2 (.clk(clk), .reset(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .a(a_s[13:0]), .b(b_s[13:0]), .cin(cin_s), .sub(sub_s), .out_valid(ov[2]), .out_ready(ordy), .sum(s2), .cout(co[2]), .ovf(vf[2]));
    bk_adder_pipe #(.WIDTH(53), .PIPE_STAGES(1)) u3 (.clk(clk), .reset(rst), .in_valid(iv[3]), .in_ready(ir[3]),
        .a(a_s[52:0]), .b(b_s[52:0]), .cin(cin_s), .sub(sub_s), .out_valid(ov[3]), .out_ready(ordy), .sum(s3), .cout(co[3]), .ovf(vf[3]));
    bk_adder_pipe #(.WIDTH(2), .PIPE_STAGES(1)) u4 (.clk(clk), .reset(rst), .in_valid(iv[4]), .in_ready(ir[4]),
        .a(a_s[1:0]), .b(b_s[1:0]), .cin(cin_s), .sub(sub_s), .out_valid(ov[4]), .out_ready(ordy), .sum(s4), .cout(co[4]), .ovf(vf[4]));
    bk_adder_pipe #(.WIDTH(64), .PIPE_STAGES(11)) u5 (.clk(clk), .reset(rst), .in_valid(iv[5]), .in_ready(ir[5]),
        .a(a_s), .b(b_s), .cin(cin_s), .sub(sub_s), .out_valid(ov[5]), .out_ready(ordy), .sum(s5), .cout(co[5]), .ovf(vf[5]));

    always_comb begin
        case (sel)
            0:       sum_m = {32'b0, s0};
            1:       sum_m = {32'b0, s1};
            2:       sum_m = {50'b0, s2};
            3:       sum_m = {11'b0, s3};
            4:       sum_m = {62'b0, s4};
            default: sum_m = s5;
        endcase
    end

    function automatic int width_of(input int d);
        case (d)
            0, 1:    return 32;
            2:       return 14;
            3:       return 53;
            4:       return 2;
            default: return 64;
        endcase
    endfunction

    function automatic int stages_of(input int d);
        case (d)
            0:       return 2;
            1:       return 3;
            2:       return 7;
            3, 4:    return 1;
            default: return 11;
        endcase
    endfunction

    // Reference result {ovf, cout, sum} from plain wide arithmetic.
    function automatic logic [65:0] model(input int d, input logic [63:0] ta, input logic [63:0] tb_,
                                          input logic tc, input logic ts);
        int          w;
        logic [64:0] mask, aa, bb, t;
        logic        c0, ov_b;
        w    = width_of(d);
        mask = (65'd1 << w) - 65'd1;
        aa   = {1'b0, ta} & mask;
        bb   = (ts ? ~{1'b0, tb_} : {1'b0, tb_}) & mask;
        c0   = ts ? 1'b1 : tc;
        t    = aa + bb + {64'd0, c0};
        ov_b = (aa[w-1] == bb[w-1]) && (t[w-1] != aa[w-1]);
        return {ov_b, t[w], t[63:0] & mask[63:0]};
    endfunction

    task automatic chk(input string nm, input logic [65:0] got, input logic [65:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut=%0d got=%h exp=%h", nm, sel, got, exp);
        end
    endtask

    // One clock of traffic on DUT 'sel': scoreboard push on accept, compare on delivery.
    task automatic step(input bit v, input bit r, input logic [63:0] ta, input logic [63:0] tb_,
                        input logic tc, input logic ts, output bit acc);
        logic [65:0] exp;
        @(negedge clk);
        iv    = v ? (6'b1 << sel) : 6'b0;
        ordy  = r;
        a_s   = ta;
        b_s   = tb_;
        cin_s = tc;
        sub_s = ts;
        #1;
        acc = v && ir[sel];
        if (ov[sel] && r) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out dut=%0d got=%h exp=none", sel, sum_m);
            end else begin
                exp = sb.pop_front();
                npop++;
                chk("beat", {vf[sel], co[sel], sum_m}, exp);
            end
        end
        if (acc) sb.push_back(model(sel, ta, tb_, tc, ts));
        @(posedge clk);
    endtask

    typedef struct {
        logic [31:0] a, b;
        logic        cin, sub;
        logic [31:0] sum;
        logic        cout, ovf;
    } vec_t;

    vec_t tbl [12];

    task automatic send_one(input vec_t t);
        int lat;
        bit got;
        @(negedge clk);
        iv = 6'b1; ordy = 1'b1;
        a_s = {32'b0, t.a}; b_s = {32'b0, t.b}; cin_s = t.cin; sub_s = t.sub;
        #1;
        chk("in_ready", {65'b0, ir[0]}, 66'd1);
        @(posedge clk);
        lat = 0;
        got = 1'b0;
        while (lat < 10 && !got) begin
            @(negedge clk);
            iv = 6'b0;
            #1;
            lat++;
            if (ov[0]) got = 1'b1;
            else @(posedge clk);
        end
        chk("latency", 66'(lat), 66'd2);
        chk("result", {vf[0], co[0], sum_m}, {t.ovf, t.cout, 32'b0, t.sum});
        @(posedge clk);
        #1;
        chk("empty_hold", {1'b0, ov[0], sum_m}, {2'b0, 32'b0, t.sum});
    endtask

    initial begin
        bit acc;
        int nacc;
        int pop0;

        tbl[0]  = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
        tbl[1]  = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
        tbl[2]  = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        tbl[3]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
        tbl[4]  = '{32'h12345678, 32'h87654321, 1'b0, 1'b0, 32'h99999999, 1'b0, 1'b0};
        tbl[5]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
        tbl[6]  = '{32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0};
        tbl[7]  = '{32'h00000000, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0};
        tbl[8]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
        tbl[9]  = '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0};
        tbl[10] = '{32'h00000000, 32'h00000001, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0};
        tbl[11] = '{32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};

        sel = 0; rst = 1'b1; iv = 6'b0; ordy = 1'b0;
        a_s = '0; b_s = '0; cin_s = 1'b0; sub_s = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", {60'b0, ov}, 66'd0);
        chk("reset_result", {vf[0], co[0], sum_m}, 66'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_in_ready", {60'b0, ir}, 66'h3F);

        for (int i = 0; i < 12; i++) send_one(tbl[i]);

        // Reset with two beats in flight.
        sel = 0;
        step(1'b1, 1'b0, 64'h1, 64'h2, 1'b0, 1'b0, acc);
        step(1'b1, 1'b0, 64'h3, 64'h4, 1'b0, 1'b0, acc);
        @(negedge clk);
        rst = 1'b1; iv = 6'b1; ordy = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_midflight_out_valid", {65'b0, ov[0]}, 66'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0; iv = 6'b0;
        #1;
        chk("rst_in_ready", {65'b0, ir[0]}, 66'd1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 64'h0, 64'h0, 1'b0, 1'b0, acc);
            #1;
            chk("rst_no_ghost", {65'b0, ov[0]}, 66'd0);
        end
        send_one(tbl[3]);

        // Backpressure on S=3: 6 stalled cycles then drain, 10 beats in order.
        sel = 1; nacc = 0; pop0 = npop;
        for (int c = 0; c < 6; c++) begin
            step(nacc < 10, 1'b0, 64'h7FFFFFF0 + 64'(nacc) * 64'h01010101, 64'(nacc * 3),
                 nacc[0], (nacc % 3) == 0, acc);
            if (acc) nacc++;
            #1;
            if (ov[1]) chk("stall_hold", {2'b0, sum_m}, {2'b0, sb[0][63:0]});
        end
        chk("full_in_ready", {65'b0, ir[1]}, 66'd0);
        chk("accepted_before_full", 66'(nacc), 66'd3);
        for (int c = 0; c < 60 && (nacc < 10 || sb.size() != 0); c++) begin
            step(nacc < 10, 1'b1, 64'h7FFFFFF0 + 64'(nacc) * 64'h01010101, 64'(nacc * 3),
                 nacc[0], (nacc % 3) == 0, acc);
            if (acc) nacc++;
        end
        chk("bp_accepted", 66'(nacc), 66'd10);
        chk("bp_delivered", 66'(npop - pop0), 66'd10);
        chk("bp_empty", 66'(sb.size()), 66'd0);

        // Random traffic on every build.
        for (int d = 0; d < 6; d++) begin
            sel = d;
            for (int c = 0; c < 2200; c++) begin
                logic [63:0] ra, rb;
                ra = ($urandom_range(0, 7) == 0) ? 64'hFFFFFFFFFFFFFFFF : {$urandom, $urandom};
                rb = ($urandom_range(0, 7) == 0) ? 64'h0 : {$urandom, $urandom};
                step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, ra, rb,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), acc);
            end
            for (int c = 0; c < 40 && sb.size() != 0; c++)
                step(1'b0, 1'b1, 64'h0, 64'h0, 1'b0, 1'b0, acc);
            chk("random_drain", 66'(sb.size()), 66'd0);
            if (stages_of(d) < 1) chk("stage_cfg", 66'(stages_of(d)), 66'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
